twiddle_gen: RTL and testbench

Self-sequencing twiddle-factor generator for one R2²SDF stage. It counts incoming data beats and derives the stage twiddle number for each beat. It folds that number into the first octant, reads a 1/8-period coefficient table and restores the full-circle value by swap and negation. It sits beside the stage complex multiplier and delivers aligned twiddles with a valid strobe and a trivial-unity flag, replacing an external full-size ROM.

---
 rtl/twiddle_gen_pkg.sv | 17 +
 rtl/twiddle_gen_if.sv | 13 +
 rtl/twiddle_gen_rom.sv | 33 +++
 rtl/twiddle_gen.sv | 97 +++++++++
 tb/tb_twiddle_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/twiddle_gen_pkg.sv
// twiddle_pkg: octant type, group-to-multiplier map and Q1.(W-1) constants shared by the twiddle generator.
package twiddle_pkg;
  typedef enum logic [2:0] {o0, o1, o2, o3, o4, o5, o6, o7} octant_t;
  // g0->0, g1->2, g2->1, g3->3 is a plain bit reversal of the group index
  function automatic logic [1:0] grp_mul(input logic [1:0] g);
    return {g[0], g[1]};
  endfunction
  function automatic longint q_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint q_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
  function automatic longint q_c(input int w);
    return longint'(0.70710678118654752 * (2.0 ** (w - 1)));
  endfunction
endpackage

// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: beat strobe in, aligned twiddle out; the inv conjugate request exists only with TWIDDLE_GEN_INV_EN.
interface twiddle_gen_if #(parameter int WIDTH = 16);
  logic sclr, di_en, do_en, do_one;
  logic [WIDTH-1:0] do_r, do_i;
`ifdef TWIDDLE_GEN_INV_EN
  logic inv;
  modport master (output sclr, di_en, inv, input do_en, do_r, do_i, do_one);
  modport slave (input sclr, di_en, inv, output do_en, do_r, do_i, do_one);
`else
  modport master (output sclr, di_en, input do_en, do_r, do_i, do_one);
  modport slave (input sclr, di_en, output do_en, do_r, do_i, do_one);
`endif
endinterface

// File: rtl/twiddle_gen_rom.sv
// twiddle_rom: registered read of the first-octant (cos, -sin) table; contents are computed at elaboration.
module twiddle_rom import twiddle_pkg::*; #(
  parameter int LOG_N = 6,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [LOG_N-4:0] addr,
  output logic [WIDTH-1:0] tr,
  output logic [WIDTH-1:0] ti
);
  localparam int D = 1 << (LOG_N - 3);
  function automatic logic [2*WIDTH-1:0] entry(input int a);
    real th, sc;
    longint c, s;
    th = 2.0 * 3.14159265358979323846 * a / (2.0 ** LOG_N);
    sc = 2.0 ** (WIDTH - 1);
    c = longint'($cos(th) * sc);
    s = longint'(-$sin(th) * sc);
    // narrow words with large N can round cos up to +1.0
    if (c > q_max(WIDTH)) c = q_max(WIDTH);
    return {c[WIDTH-1:0], s[WIDTH-1:0]};
  endfunction
  logic [2*WIDTH-1:0] tab [D];
  for (genvar a = 0; a < D; a++) begin : g_tab
    localparam logic [2*WIDTH-1:0] E = entry(a);
    assign tab[a] = E;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) {tr, ti} <= '0;
    else if (en) {tr, ti} <= tab[addr];
endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: self-sequencing R2^2SDF stage twiddle source with octant folding.
// Define TWIDDLE_GEN_INV_EN to add the per-beat conjugate (inv) request.
module twiddle_gen import twiddle_pkg::*; #(
  parameter int LOG_N = 6,
  parameter int WIDTH = 16,
  parameter int OUT_FF = 1
) (
  input logic        clock,
  input logic        reset,
  twiddle_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] CC = WIDTH'(q_c(WIDTH));
  localparam logic [WIDTH-1:0] MX = WIDTH'(q_max(WIDTH));
  localparam logic [WIDTH-1:0] MN = WIDTH'(q_min(WIDTH));
  localparam logic [WIDTH-1:0] Z = '0;
  logic [LOG_N-1:0] t, t_cur, lo_ext, m_ext, k, k1;
  logic [LOG_N-4:0] r, a, a1;
  logic [WIDTH-1:0] tr, ti, ur, ui, fi;
  octant_t oct1, oct2;
  logic v1, v2, rz2, one2;
  // sclr restarts the frame so a coincident beat is generated as t = 0
  assign t_cur = bus.sclr ? '0 : t;
  assign lo_ext = {2'b00, t_cur[LOG_N-3:0]};
  assign m_ext = {{(LOG_N-2){1'b0}}, grp_mul(t_cur[LOG_N-1:LOG_N-2])};
  assign k = lo_ext * m_ext;
  assign r = k[LOG_N-4:0];
  assign a = k[LOG_N-3] ? -r : r;
  always_ff @(posedge clock or posedge reset)
    if (reset) t <= '0;
    else if (bus.sclr || bus.di_en) t <= bus.di_en ? t_cur + 1'b1 : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {v1, k1, a1} <= '0;
      oct1 <= o0;
    end else begin
      v1 <= bus.di_en;
      if (bus.di_en) begin
        k1 <= k;
        a1 <= a;
        oct1 <= octant_t'(k[LOG_N-1:LOG_N-3]);
      end
    end
  twiddle_rom #(.LOG_N(LOG_N), .WIDTH(WIDTH)) u_rom (
    .clock(clock), .reset(reset), .en(v1), .addr(a1), .tr(tr), .ti(ti)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {v2, rz2, one2} <= '0;
      oct2 <= o0;
    end else begin
      v2 <= v1;
      if (v1) begin
        oct2 <= oct1;
        rz2 <= k1[LOG_N-4:0] == '0;
        one2 <= k1 == '0;
      end
    end
  always_comb begin
    {ur, ui} = '0;
    case (oct2)
      o0: {ur, ui} = rz2 ? {MX, Z} : {tr, ti};
      o1: {ur, ui} = rz2 ? {CC, -CC} : {-ti, -tr};
      o2: {ur, ui} = rz2 ? {Z, MN} : {ti, -tr};
      o3: {ur, ui} = rz2 ? {-CC, -CC} : {-tr, ti};
      o4: {ur, ui} = rz2 ? {MN, Z} : {-tr, -ti};
      o5: {ur, ui} = rz2 ? {-CC, CC} : {ti, tr};
      o6: {ur, ui} = rz2 ? {Z, MX} : {-ti, tr};
      o7: {ur, ui} = rz2 ? {CC, CC} : {tr, -ti};
      default: {ur, ui} = '0;
    endcase
  end
`ifdef TWIDDLE_GEN_INV_EN
  logic inv1, inv2;
  always_ff @(posedge clock or posedge reset)
    if (reset) {inv1, inv2} <= '0;
    else begin
      if (bus.di_en) inv1 <= bus.inv;
      if (v1) inv2 <= inv1;
    end
  assign fi = inv2 ? (ui == MN ? MX : -ui) : ui;
`else
  assign fi = ui;
`endif
  if (OUT_FF != 0) begin : g_ff
    always_ff @(posedge clock or posedge reset)
      if (reset) {bus.do_en, bus.do_r, bus.do_i, bus.do_one} <= '0;
      else begin
        bus.do_en <= v2;
        if (v2) {bus.do_r, bus.do_i, bus.do_one} <= {ur, fi, one2};
      end
  end else begin : g_comb
    assign bus.do_en = v2;
    assign bus.do_r = ur;
    assign bus.do_i = fi;
    assign bus.do_one = one2;
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: drives OUT_FF=1 and OUT_FF=0 instances in lockstep against a direct cos/sin reference.
module tb_twiddle_gen;
  localparam int N = 64;
  localparam real PI = 3.14159265358979323846;
  logic clock = 0, reset = 1, di_en = 0, sclr = 0, inv = 0;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  twiddle_gen_if #(.WIDTH(16)) b1 ();
  twiddle_gen_if #(.WIDTH(16)) b0 ();
  assign b1.di_en = di_en;
  assign b1.sclr = sclr;
  assign b0.di_en = di_en;
  assign b0.sclr = sclr;
`ifdef TWIDDLE_GEN_INV_EN
  assign b1.inv = inv;
  assign b0.inv = inv;
`endif
  twiddle_gen #(.LOG_N(6), .WIDTH(16), .OUT_FF(1)) dut (.clock(clock), .reset(reset), .bus(b1));
  twiddle_gen #(.LOG_N(6), .WIDTH(16), .OUT_FF(0)) dut0 (.clock(clock), .reset(reset), .bus(b0));

  typedef struct packed {logic v; logic [5:0] t; logic [15:0] r; logic [15:0] i; logic one;} beat_t;
  beat_t h0, h1, h2, e1, e0, nb;
  int mt, tt, kk;

  function automatic logic [15:0] q(input real x);
    longint v = longint'(x * 32768.0);
    return v > 32767 ? 16'h7FFF : v < -32768 ? 16'h8000 : 16'(v);
  endfunction
  function automatic logic [31:0] twid(input int k, input logic cj);
    real th = 2.0 * PI * k / N;
    return {q($cos(th)), q(cj ? $sin(th) : -$sin(th))};
  endfunction
  function automatic int gmul(input int g);
    return g == 1 ? 2 : g == 2 ? 1 : g;
  endfunction

  // reference: beat number -> k -> exact rotation, then a plain latency delay with hold
  always @(posedge clock or posedge reset)
    if (reset) begin
      mt = 0; h0 = '0; h1 = '0; h2 = '0; e1 = '0; e0 = '0;
    end else begin
      tt = sclr ? 0 : mt;
      if (sclr || di_en) mt = di_en ? (tt + 1) % N : 0;
      kk = (tt % (N / 4)) * gmul(tt / (N / 4));
      nb = '0;
      nb.v = di_en;
      nb.t = 6'(tt);
      nb.one = kk == 0;
      {nb.r, nb.i} = twid(kk, inv);
      h2 = h1; h1 = h0; h0 = nb;
      if (h2.v) e1 = h2; else e1.v = 0;
      if (h1.v) e0 = h1; else e0.v = 0;
    end

  task automatic test_reset;
    reset = 1;
    #12;
    checks += 2;
    if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== 34'h0) begin failures++; $display("FAIL reset_ff1 got=%h exp=0", {b1.do_en, b1.do_r, b1.do_i, b1.do_one}); end
    if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== 34'h0) begin failures++; $display("FAIL reset_ff0 got=%h exp=0", {b0.do_en, b0.do_r, b0.do_i, b0.do_one}); end
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_stream;
    int rise1 = -1, rise0 = -1;
    for (int j = 0; j < 70; j++) begin
      @(negedge clock);
      checks += 2;
      if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {e1.v, e1.r, e1.i, e1.one}) begin failures++; $display("FAIL stream_ff1 j=%0d got=%h exp=%h", j, {b1.do_en, b1.do_r, b1.do_i, b1.do_one}, {e1.v, e1.r, e1.i, e1.one}); end
      if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== {e0.v, e0.r, e0.i, e0.one}) begin failures++; $display("FAIL stream_ff0 j=%0d got=%h exp=%h", j, {b0.do_en, b0.do_r, b0.do_i, b0.do_one}, {e0.v, e0.r, e0.i, e0.one}); end
      if (b1.do_en && rise1 < 0) rise1 = j;
      if (b0.do_en && rise0 < 0) rise0 = j;
      if (e1.v && e1.t < 16) begin checks++; if ({b1.do_r, b1.do_i, b1.do_one} !== {16'h7FFF, 16'h0000, 1'b1}) begin failures++; $display("FAIL unity t=%0d got=%h exp=7fff00001", e1.t, {b1.do_r, b1.do_i, b1.do_one}); end end
      if (e1.v && e1.t == 20) begin checks++; if ({b1.do_r, b1.do_i, b1.do_one} !== {16'h5A82, 16'hA57E, 1'b0}) begin failures++; $display("FAIL k8 got=%h exp=5a82a57e0", {b1.do_r, b1.do_i, b1.do_one}); end end
      if (e1.v && e1.t == 24) begin checks++; if ({b1.do_r, b1.do_i, b1.do_one} !== {16'h0000, 16'h8000, 1'b0}) begin failures++; $display("FAIL k16 got=%h exp=000080000", {b1.do_r, b1.do_i, b1.do_one}); end end
      if (e1.v && e1.t == 63) begin checks++; if ({b1.do_r, b1.do_i, b1.do_one} !== {16'hDAD8, 16'h7A7D, 1'b0}) begin failures++; $display("FAIL k45 got=%h exp=dad87a7d0", {b1.do_r, b1.do_i, b1.do_one}); end end
      di_en = j < 64;
    end
    checks += 2;
    if (rise1 !== 3) begin failures++; $display("FAIL latency_ff1 got=%0d exp=3", rise1); end
    if (rise0 !== 2) begin failures++; $display("FAIL latency_ff0 got=%0d exp=2", rise0); end
  endtask

`ifdef TWIDDLE_GEN_INV_EN
  task automatic test_inv;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      checks += 2;
      if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {e1.v, e1.r, e1.i, e1.one}) begin failures++; $display("FAIL inv_ff1 j=%0d got=%h exp=%h", j, {b1.do_en, b1.do_r, b1.do_i, b1.do_one}, {e1.v, e1.r, e1.i, e1.one}); end
      if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== {e0.v, e0.r, e0.i, e0.one}) begin failures++; $display("FAIL inv_ff0 j=%0d got=%h exp=%h", j, {b0.do_en, b0.do_r, b0.do_i, b0.do_one}, {e0.v, e0.r, e0.i, e0.one}); end
      if (e1.v && e1.t == 24) begin checks++; if ({b1.do_r, b1.do_i} !== {16'h0000, 16'h7FFF}) begin failures++; $display("FAIL inv_sat got=%h exp=00007fff", {b1.do_r, b1.do_i}); end end
      di_en = j < 32;
      inv = j == 17 || j == 24;
    end
  endtask
`endif

  task automatic test_sclr;
    for (int j = 0; j < 50; j++) begin
      @(negedge clock);
      checks += 2;
      if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {e1.v, e1.r, e1.i, e1.one}) begin failures++; $display("FAIL sclr_ff1 j=%0d got=%h exp=%h", j, {b1.do_en, b1.do_r, b1.do_i, b1.do_one}, {e1.v, e1.r, e1.i, e1.one}); end
      if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== {e0.v, e0.r, e0.i, e0.one}) begin failures++; $display("FAIL sclr_ff0 j=%0d got=%h exp=%h", j, {b0.do_en, b0.do_r, b0.do_i, b0.do_one}, {e0.v, e0.r, e0.i, e0.one}); end
      if (j == 44) begin checks++; if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {1'b1, 16'h7FFF, 16'h0000, 1'b1}) begin failures++; $display("FAIL sclr_beat got=%h exp=17fff00001", {b1.do_en, b1.do_r, b1.do_i, b1.do_one}); end end
      di_en = j >= 1 && j <= 43;
      sclr = j == 0 || j == 41;
    end
  endtask

  task automatic test_gaps;
    logic [4:0] pat = 5'b11001;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      checks += 2;
      if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {e1.v, e1.r, e1.i, e1.one}) begin failures++; $display("FAIL gaps_ff1 j=%0d got=%h exp=%h", j, {b1.do_en, b1.do_r, b1.do_i, b1.do_one}, {e1.v, e1.r, e1.i, e1.one}); end
      if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== {e0.v, e0.r, e0.i, e0.one}) begin failures++; $display("FAIL gaps_ff0 j=%0d got=%h exp=%h", j, {b0.do_en, b0.do_r, b0.do_i, b0.do_one}, {e0.v, e0.r, e0.i, e0.one}); end
      if (j >= 2 && j < 7) begin checks++; if (b0.do_en !== pat[j-2]) begin failures++; $display("FAIL gaps_en j=%0d got=%b exp=%b", j, b0.do_en, pat[j-2]); end end
      di_en = j < 5 ? pat[j] : 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      di_en = 1;
    end
    @(negedge clock);
    #2 reset = 1;
    #1;
    checks += 2;
    if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== 34'h0) begin failures++; $display("FAIL midreset_ff1 got=%h exp=0", {b1.do_en, b1.do_r, b1.do_i, b1.do_one}); end
    if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== 34'h0) begin failures++; $display("FAIL midreset_ff0 got=%h exp=0", {b0.do_en, b0.do_r, b0.do_i, b0.do_one}); end
    @(negedge clock);
    reset = 0;
    di_en = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      checks += 2;
      if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {e1.v, e1.r, e1.i, e1.one}) begin failures++; $display("FAIL after_reset_ff1 j=%0d got=%h exp=%h", j, {b1.do_en, b1.do_r, b1.do_i, b1.do_one}, {e1.v, e1.r, e1.i, e1.one}); end
      if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== {e0.v, e0.r, e0.i, e0.one}) begin failures++; $display("FAIL after_reset_ff0 j=%0d got=%h exp=%h", j, {b0.do_en, b0.do_r, b0.do_i, b0.do_one}, {e0.v, e0.r, e0.i, e0.one}); end
      if (j == 3) begin checks++; if ({b1.do_en, b1.do_r, b1.do_one} !== {1'b1, 16'h7FFF, 1'b1}) begin failures++; $display("FAIL first_after_reset got=%h exp=17fff1", {b1.do_en, b1.do_r, b1.do_one}); end end
      di_en = j < 2;
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 400; j++) begin
      @(negedge clock);
      checks += 2;
      if ({b1.do_en, b1.do_r, b1.do_i, b1.do_one} !== {e1.v, e1.r, e1.i, e1.one}) begin failures++; $display("FAIL random_ff1 j=%0d got=%h exp=%h", j, {b1.do_en, b1.do_r, b1.do_i, b1.do_one}, {e1.v, e1.r, e1.i, e1.one}); end
      if ({b0.do_en, b0.do_r, b0.do_i, b0.do_one} !== {e0.v, e0.r, e0.i, e0.one}) begin failures++; $display("FAIL random_ff0 j=%0d got=%h exp=%h", j, {b0.do_en, b0.do_r, b0.do_i, b0.do_one}, {e0.v, e0.r, e0.i, e0.one}); end
      di_en = $urandom_range(0, 3) != 0;
      sclr = $urandom_range(0, 31) == 0;
`ifdef TWIDDLE_GEN_INV_EN
      inv = $urandom_range(0, 1) == 1;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stream();
`ifdef TWIDDLE_GEN_INV_EN
    test_inv();
`endif
    test_sclr();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
